miner_dispatch: RTL and testbench

Multi-core job dispatcher for the bitcoin miner top. It sits between the UART receive path and `CORES` hash cores, and between those cores and the UART transmit path. It accepts a received job word, splits the nonce space evenly across the cores and starts them. It then reports the first solution found, or optionally reports exhaustion, as one transmit frame. A new job arriving while the cores run preempts the current job.

---
 rtl/miner_pkg.sv | 13 +
 rtl/miner_rr_arbiter.sv | 22 ++
 rtl/miner_dispatch.sv | 96 +++++++++
 tb/tb_miner_dispatch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared dispatcher state encoding, default widths and the no-solution frame builder
package miner_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, SEND} dispatch_state_t;
  localparam int NONCE_W_DEF = 32;
  localparam int RESULT_W_DEF = 288;
  localparam int FRAME_MAX_W = 1024;
  function automatic logic [FRAME_MAX_W-1:0] nosol_frame(input int nonce_w, input int result_w);
    logic [FRAME_MAX_W-1:0] f;
    f = '0;
    for (int i = result_w - nonce_w; i < result_w; i++) f[i] = 1'b1;
    return f;
  endfunction
endpackage

// File: rtl/miner_rr_arbiter.sv
// miner_rr_arbiter: combinational round-robin grant over req, search starts at ptr; ports req/ptr in, grant (one-hot)/idx out
module miner_rr_arbiter import miner_pkg::*; #(
  parameter int CORES = 4,
  parameter int PW = CORES > 1 ? $clog2(CORES) : 1
) (
  input  logic [CORES-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [CORES-1:0] grant,
  output logic [PW-1:0]    idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % CORES]) begin
        grant = '0;
        grant[(int'(ptr) + k) % CORES] = 1'b1;
        idx = PW'((int'(ptr) + k) % CORES);
      end
    end
  end
endmodule

// File: rtl/miner_dispatch.sv
// miner_dispatch: job dispatcher for CORES hash cores; job_*/core_* in, core_job/nonce ranges/start/abort out, tx_data/send_data to transmitter; MINER_NOSOL_REPORT_EN enables the exhaustion frame
module miner_dispatch import miner_pkg::*; #(
  parameter int CORES = 4,
  parameter int JOB_W = 864,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int RESULT_W = RESULT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [JOB_W-1:0]          job_data,
  input  logic                      job_valid,
  output logic                      job_ready,
  output logic [JOB_W-1:0]          core_job,
  output logic [CORES*NONCE_W-1:0]  core_nonce_base,
  output logic [CORES*NONCE_W-1:0]  core_nonce_last,
  output logic [CORES-1:0]          core_start,
  output logic [CORES-1:0]          core_abort,
  input  logic [CORES-1:0]          core_found,
  input  logic [CORES-1:0]          core_done,
  input  logic [CORES*RESULT_W-1:0] core_result,
  output logic [RESULT_W-1:0]       tx_data,
  output logic                      send_data,
  input  logic                      tx_busy
);
  localparam int SH = $clog2(CORES);
  localparam int PW = CORES > 1 ? SH : 1;
`ifdef MINER_NOSOL_REPORT_EN
  localparam logic [RESULT_W-1:0] NOSOL = RESULT_W'(nosol_frame(NONCE_W, RESULT_W));
`endif
  dispatch_state_t state, state_n;
  logic [PW-1:0] rr_ptr, ptr_n, gidx;
  logic [CORES-1:0] grant;
  logic [RESULT_W-1:0] tx_n;
  logic abort_q, abort_n, job_ld, accept;
  genvar i;
  for (i = 0; i < CORES; i++) begin : g_split
    assign core_nonce_base[i*NONCE_W +: NONCE_W] = NONCE_W'(i) << (NONCE_W - SH);
    assign core_nonce_last[i*NONCE_W +: NONCE_W] = (NONCE_W'(i) << (NONCE_W - SH)) | ({NONCE_W{1'b1}} >> SH);
  end
  miner_rr_arbiter #(.CORES(CORES), .PW(PW)) u_arb (.req(core_found), .ptr(rr_ptr), .grant(grant), .idx(gidx));
  assign job_ready = ~rst & (state == IDLE | (state == RUN & ~|core_found & ~&core_done));
  assign accept = job_valid & job_ready;
  // a preempt lands in START with abort_q set; start waits one cycle so abort and start never overlap
  assign core_start = {CORES{state == START & ~abort_q}};
  assign core_abort = {CORES{abort_q}};
  assign send_data = state == SEND & ~tx_busy;
  always_comb begin
    state_n = state;
    ptr_n = rr_ptr;
    tx_n = tx_data;
    abort_n = 1'b0;
    job_ld = 1'b0;
    case (state)
      IDLE: begin
        job_ld = accept;
        state_n = accept ? START : IDLE;
      end
      START: state_n = abort_q ? START : RUN;
      RUN: begin
        if (|grant) begin
          tx_n = core_result[int'(gidx)*RESULT_W +: RESULT_W];
          ptr_n = PW'((int'(gidx) + 1) % CORES);
          abort_n = 1'b1;
          state_n = SEND;
        end else if (&core_done) begin
`ifdef MINER_NOSOL_REPORT_EN
          tx_n = NOSOL;
          state_n = SEND;
`else
          state_n = IDLE;
`endif
        end else if (accept) begin
          abort_n = 1'b1;
          job_ld = 1'b1;
          state_n = START;
        end
      end
      SEND: state_n = tx_busy ? SEND : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      core_job <= '0;
      tx_data <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= ptr_n;
      tx_data <= tx_n;
      abort_q <= abort_n;
      if (job_ld) core_job <= job_data;
    end
  end
endmodule

// File: tb/tb_miner_dispatch.sv
// tb_miner_dispatch: self-checking bench for miner_dispatch with CORES=4
module tb_miner_dispatch;
  logic clk, rst, job_valid, job_ready, send_data, tx_busy;
  logic [863:0] job_data, core_job;
  logic [127:0] core_nonce_base, core_nonce_last;
  logic [3:0] core_start, core_abort, core_found, core_done;
  logic [1151:0] core_result;
  logic [287:0] tx_data;
  logic [287:0] sb[$];
  int pass_cnt = 0, total_cnt = 0;

  miner_dispatch dut (
    .clk(clk), .rst(rst), .job_data(job_data), .job_valid(job_valid), .job_ready(job_ready),
    .core_job(core_job), .core_nonce_base(core_nonce_base), .core_nonce_last(core_nonce_last),
    .core_start(core_start), .core_abort(core_abort), .core_found(core_found), .core_done(core_done),
    .core_result(core_result), .tx_data(tx_data), .send_data(send_data), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [863:0] act, input logic [863:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  function automatic logic [287:0] res(input int i);
    return {(32'(i) << 30) | 32'h0000_1234, {8{32'hA5A5_0000 | 32'(i)}}};
  endfunction

  function automatic logic [863:0] mk_job(input int s);
    return {27{32'(s) * 32'h9E37_79B9 + 32'h0101_0101}};
  endfunction

  task automatic start_job(input logic [863:0] j);
    job_data = j;
    job_valid = 1'b1;
    #1 chk("accept_ready", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
    chk("start_pulse", core_start, 4'hF);
    chk("core_job", core_job, j);
    @(negedge clk);
    chk("start_off", core_start, 0);
  endtask

  task automatic expect_send(input int busy, input bit exp_abort);
    int pulses, at;
    pulses = 0;
    at = -1;
    @(negedge clk);
    core_found = '0;
    core_done = '0;
    job_valid = 1'b0;
    chk("send_abort", core_abort, exp_abort ? 4'hF : 4'h0);
    for (int c = 0; c < busy + 3; c++) begin
      tx_busy = (c < busy);
      #1;
      if (send_data) begin
        pulses++;
        at = c;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("tx_frame", tx_data, sb.pop_front());
      end
      @(negedge clk);
    end
    chk("send_count", pulses, 1);
    chk("send_cycle", at, busy);
    chk("idle_ready", job_ready, 1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          busy;
    bit          with_job;
    int          exp_core;
    logic [31:0] exp_nonce;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [863:0] j;
    tbl[0] = '{4'b0100, 0, 1'b0, 2, 32'h8000_1234};
    tbl[1] = '{4'b0001, 0, 1'b0, 0, 32'h0000_1234};
    tbl[2] = '{4'b1001, 5, 1'b0, 3, 32'hC000_1234};
    tbl[3] = '{4'b1001, 0, 1'b0, 0, 32'h0000_1234};
    tbl[4] = '{4'b1110, 2, 1'b1, 1, 32'h4000_1234};
    tbl[5] = '{4'b1111, 0, 1'b0, 2, 32'h8000_1234};
    rst = 1'b1;
    job_valid = 1'b0;
    job_data = '0;
    core_found = '0;
    core_done = '0;
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) core_result[i*288 +: 288] = res(i);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", job_ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_abort", core_abort, 0);
    chk("rst_send", send_data, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_job", core_job, 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", job_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("base%0d", i), core_nonce_base[i*32 +: 32], 32'(i) * 32'h4000_0000);
      chk($sformatf("last%0d", i), core_nonce_last[i*32 +: 32], 32'(i) * 32'h4000_0000 + 32'h3FFF_FFFF);
    end
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      j = mk_job(v + 1);
      start_job(j);
      core_found = tbl[v].mask;
      tx_busy = tbl[v].busy > 0;
      if (tbl[v].with_job) begin
        job_data = mk_job(99);
        job_valid = 1'b1;
      end
      sb.push_back(res(tbl[v].exp_core));
      expect_send(tbl[v].busy, 1'b1);
      chk($sformatf("v%0d_nonce", v), tx_data[287:256], tbl[v].exp_nonce);
      chk($sformatf("v%0d_job_kept", v), core_job, j);
    end
    start_job(mk_job(20));
    core_done = 4'hF;
    #1 chk("done_ready", job_ready, 0);
`ifdef MINER_NOSOL_REPORT_EN
    sb.push_back({32'hFFFF_FFFF, 256'h0});
    expect_send(0, 1'b0);
    chk("nosol_nonce", tx_data[287:256], 32'hFFFF_FFFF);
`else
    @(negedge clk);
    core_done = '0;
    chk("exh_send", send_data, 0);
    chk("exh_abort", core_abort, 0);
    chk("exh_ready", job_ready, 1);
    @(negedge clk);
    chk("exh_send2", send_data, 0);
`endif
    start_job(mk_job(30));
    @(negedge clk);
    job_data = mk_job(31);
    job_valid = 1'b1;
    #1 chk("pre_ready", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
    chk("pre_abort", core_abort, 4'hF);
    chk("pre_nostart", core_start, 0);
    chk("pre_job", core_job, mk_job(31));
    @(negedge clk);
    chk("pre_start", core_start, 4'hF);
    chk("pre_abort_off", core_abort, 0);
    @(negedge clk);
    chk("pre_start_off", core_start, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", job_ready, 0);
    chk("mid_rst_tx", tx_data, 0);
    chk("mid_rst_job", core_job, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_pulses", {core_start, core_abort, send_data}, 0);
    end
    rst = 1'b0;
    #1 chk("mid_rst_idle", job_ready, 1);
    @(negedge clk);
    chk("after_rst_pulses", {core_start, core_abort, send_data}, 0);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
